regwr_decoder: RTL and testbench

REGWR_DECODER -- requirements
Module: regwr_decoder

---
 rtl/regwr_pkg.sv | 13 +
 rtl/regwr_onehot.sv | 15 +
 rtl/regwr_decoder.sv | 83 ++++++++
 tb/tb_regwr_decoder.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/regwr_pkg.sv
// regwr_pkg: shared width helpers and counter width for the register write decoder
package regwr_pkg;
  localparam int CNT_W = 8;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
  function automatic int sel_width(input int n);
    return (clog2(n) > 1) ? clog2(n) : 1;
  endfunction
endpackage

// File: rtl/regwr_onehot.sv
// regwr_onehot: gated address to one-hot decode, out-of-range addresses decode to zero
module regwr_onehot #(
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32
) (
  input  logic [ADDR_W-1:0]   addr,
  input  logic                vld,
  output logic [NUM_REGS-1:0] oh
);
  // one bit per implemented register; addresses past NUM_REGS match nothing
  always_comb begin
    oh = '0;
    for (int r = 0; r < NUM_REGS; r++) oh[r] = vld && addr == ADDR_W'(r);
  end
endmodule

// File: rtl/regwr_decoder.sv
// regwr_decoder: multi-port register write decode with conflict/oor flags; REGWR_LOCK_EN adds a per-register write lock
module regwr_decoder import regwr_pkg::*; #(
  parameter int ADDR_W        = 5,
  parameter int NUM_REGS      = 32,
  parameter int NUM_PORTS     = 2,
  parameter int HARDWIRE_ZERO = 1,
  localparam int SEL_W        = sel_width(NUM_PORTS)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_PORTS-1:0]        wr_req,
  input  logic [NUM_PORTS*ADDR_W-1:0] wr_addr,
  input  logic                        cnt_clr,
  output logic [NUM_REGS-1:0]         wen_o,
  output logic [NUM_REGS*SEL_W-1:0]   wsel_o,
  output logic                        conflict_o,
  output logic                        oor_o,
  output logic [CNT_W-1:0]            conflict_cnt_o
`ifdef REGWR_LOCK_EN
  ,
  input  logic                        lock_we,
  input  logic [ADDR_W-1:0]           lock_addr,
  input  logic                        lock_val,
  output logic                        blocked_o
`endif
);
  logic [NUM_REGS-1:0] oh [NUM_PORTS];
  logic [NUM_REGS-1:0] hit, en, lk;
  logic [NUM_REGS*SEL_W-1:0] sel_n;
  logic conf, oor;
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    logic [ADDR_W-1:0] a;
    assign a = wr_addr[p*ADDR_W +: ADDR_W];
    regwr_onehot #(.ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS)) u_oh (
      .addr(a),
      .vld(wr_req[p] && !(HARDWIRE_ZERO != 0 && a == '0)),
      .oh(oh[p])
    );
  end
  // merge ports: later ports overwrite the select, so the highest index wins
  always_comb begin
    hit = '0;
    conf = 1'b0;
    oor = 1'b0;
    sel_n = wsel_o;
    for (int p = 0; p < NUM_PORTS; p++) begin
      conf = conf || (hit & oh[p]) != '0;
      hit = hit | oh[p];
      oor = oor || (wr_req[p] && 32'(wr_addr[p*ADDR_W +: ADDR_W]) >= NUM_REGS);
      for (int r = 0; r < NUM_REGS; r++) if (oh[p][r] && !lk[r]) sel_n[r*SEL_W +: SEL_W] = SEL_W'(p);
    end
    en = hit & ~lk;
  end
`ifdef REGWR_LOCK_EN
  logic [NUM_REGS-1:0] lock_q;
  assign lk = lock_q;
  // lock bitmap; writes in the same cycle still see the old state
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) lock_q <= '0;
    else if (lock_we) for (int r = 0; r < NUM_REGS; r++) if (lock_addr == ADDR_W'(r)) lock_q[r] <= lock_val;
  // pulse whenever a decoded write hits a locked register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) blocked_o <= 1'b0;
    else blocked_o <= (hit & lock_q) != '0;
`else
  assign lk = '0;
`endif
  // registered outputs and saturating conflict counter, clear wins over increment
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wen_o <= '0;
      wsel_o <= '0;
      conflict_o <= 1'b0;
      oor_o <= 1'b0;
      conflict_cnt_o <= '0;
    end else begin
      wen_o <= en;
      wsel_o <= sel_n;
      conflict_o <= conf;
      oor_o <= oor;
      conflict_cnt_o <= cnt_clr ? '0 : (conf && conflict_cnt_o != '1) ? conflict_cnt_o + 1'b1 : conflict_cnt_o;
    end
endmodule

// File: tb/tb_regwr_decoder.sv
// tb_regwr_decoder: random and directed checks of two decoder configurations against a behavioural model
module tb_regwr_decoder;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;
  logic [1:0] req_a;
  logic [9:0] addr_a;
  logic clr_a;
  logic [31:0] wen_a, wsel_a;
  logic conf_a, oor_a;
  logic [7:0] cnt_a;
  logic [2:0] req_b;
  logic [14:0] addr_b;
  logic clr_b;
  logic [23:0] wen_b;
  logic [47:0] wsel_b;
  logic conf_b, oor_b;
  logic [7:0] cnt_b;
`ifdef REGWR_LOCK_EN
  logic lwe, lval, blk_a, blk_b;
  logic [4:0] laddr;
`endif
  regwr_decoder u_a (
    .clk(clk), .rst_n(rst_n), .wr_req(req_a), .wr_addr(addr_a), .cnt_clr(clr_a),
    .wen_o(wen_a), .wsel_o(wsel_a), .conflict_o(conf_a), .oor_o(oor_a), .conflict_cnt_o(cnt_a)
`ifdef REGWR_LOCK_EN
    , .lock_we(lwe), .lock_addr(laddr), .lock_val(lval), .blocked_o(blk_a)
`endif
  );
  regwr_decoder #(.ADDR_W(5), .NUM_REGS(24), .NUM_PORTS(3), .HARDWIRE_ZERO(0)) u_b (
    .clk(clk), .rst_n(rst_n), .wr_req(req_b), .wr_addr(addr_b), .cnt_clr(clr_b),
    .wen_o(wen_b), .wsel_o(wsel_b), .conflict_o(conf_b), .oor_o(oor_b), .conflict_cnt_o(cnt_b)
`ifdef REGWR_LOCK_EN
    , .lock_we(1'b0), .lock_addr(5'd0), .lock_val(1'b0), .blocked_o(blk_b)
`endif
  );
  int rq [2][4];
  int ad [2][4];
  int cl [2];
  int lwe_i, laddr_i, lval_i;
  int m_wen [2][32];
  int m_sel [2][32];
  int m_lock [2][32];
  int m_conf [2];
  int m_oor [2];
  int m_blk [2];
  int m_cnt [2];
  int tests = 0;
  int fails = 0;
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic clear_stim();
    for (int d = 0; d < 2; d++) begin
      cl[d] = 0;
      for (int p = 0; p < 4; p++) begin
        rq[d][p] = 0;
        ad[d][p] = 0;
      end
    end
    lwe_i = 0;
    laddr_i = 0;
    lval_i = 0;
  endtask
  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_conf[d] = 0;
      m_oor[d] = 0;
      m_blk[d] = 0;
      m_cnt[d] = 0;
      for (int r = 0; r < 32; r++) begin
        m_wen[d][r] = 0;
        m_sel[d][r] = 0;
        m_lock[d][r] = 0;
      end
    end
  endtask
  task automatic step(input int d);
    int np, nr, hz, n, w;
    np = d != 0 ? 3 : 2;
    nr = d != 0 ? 24 : 32;
    hz = d != 0 ? 0 : 1;
    m_conf[d] = 0;
    m_oor[d] = 0;
    m_blk[d] = 0;
    for (int r = 0; r < 32; r++) m_wen[d][r] = 0;
    for (int p = 0; p < np; p++) if (rq[d][p] != 0 && ad[d][p] >= nr) m_oor[d] = 1;
    for (int r = 0; r < nr; r++) begin
      n = 0;
      w = -1;
      for (int p = 0; p < np; p++)
        if (rq[d][p] != 0 && ad[d][p] == r && !(hz != 0 && r == 0)) begin
          n++;
          w = p;
        end
      if (n > 1) m_conf[d] = 1;
      if (w >= 0) begin
        if (m_lock[d][r] != 0) m_blk[d] = 1;
        else begin
          m_wen[d][r] = 1;
          m_sel[d][r] = w;
        end
      end
    end
    if (cl[d] != 0) m_cnt[d] = 0;
    else if (m_conf[d] != 0 && m_cnt[d] < 255) m_cnt[d]++;
    if (d == 0 && lwe_i != 0 && laddr_i < nr) m_lock[d][laddr_i] = lval_i;
  endtask
  task automatic apply();
    req_a = '0;
    addr_a = '0;
    req_b = '0;
    addr_b = '0;
    for (int p = 0; p < 2; p++) begin
      req_a[p] = rq[0][p] != 0;
      addr_a[p*5 +: 5] = 5'(ad[0][p]);
    end
    for (int p = 0; p < 3; p++) begin
      req_b[p] = rq[1][p] != 0;
      addr_b[p*5 +: 5] = 5'(ad[1][p]);
    end
    clr_a = cl[0] != 0;
    clr_b = cl[1] != 0;
`ifdef REGWR_LOCK_EN
    lwe = lwe_i != 0;
    laddr = 5'(laddr_i);
    lval = lval_i != 0;
`endif
  endtask
  task automatic compare(input int d);
    logic [63:0] ew, es;
    int sw, nr;
    sw = d != 0 ? 2 : 1;
    nr = d != 0 ? 24 : 32;
    ew = '0;
    es = '0;
    for (int r = 0; r < nr; r++) begin
      ew[r] = m_wen[d][r] != 0;
      for (int b = 0; b < sw; b++) es[r*sw+b] = ((m_sel[d][r] >> b) & 1) != 0;
    end
    if (d == 0) begin
      check("wen_a", 64'(wen_a), ew);
      check("wsel_a", 64'(wsel_a), es);
      check("conflict_a", 64'(conf_a), 64'(m_conf[0]));
      check("oor_a", 64'(oor_a), 64'(m_oor[0]));
      check("cnt_a", 64'(cnt_a), 64'(m_cnt[0]));
`ifdef REGWR_LOCK_EN
      check("blocked_a", 64'(blk_a), 64'(m_blk[0]));
`endif
    end else begin
      check("wen_b", 64'(wen_b), ew);
      check("wsel_b", 64'(wsel_b), es);
      check("conflict_b", 64'(conf_b), 64'(m_conf[1]));
      check("oor_b", 64'(oor_b), 64'(m_oor[1]));
      check("cnt_b", 64'(cnt_b), 64'(m_cnt[1]));
`ifdef REGWR_LOCK_EN
      check("blocked_b", 64'(blk_b), 64'(m_blk[1]));
`endif
    end
  endtask
  task automatic tick();
    apply();
    @(posedge clk);
    step(0);
    step(1);
    #1;
    compare(0);
    compare(1);
  endtask
  initial begin
    rst_n = 1'b0;
    clear_stim();
    apply();
    model_reset();
    #12;
    compare(0);
    compare(1);
    @(negedge clk) rst_n = 1'b1;
    rq[0][0] = 1; ad[0][0] = 5;
    tick();
    check("wen_a_addr5", 64'(wen_a), 64'h20);
    clear_stim();
    rq[0][0] = 1; ad[0][0] = 9; rq[0][1] = 1; ad[0][1] = 9;
    tick();
    check("cnt_a_first_conflict", 64'(cnt_a), 64'd1);
    clear_stim();
    rq[0][0] = 1; ad[0][0] = 0; rq[1][0] = 1; ad[1][0] = 30;
    tick();
    clear_stim();
    for (int p = 0; p < 3; p++) rq[1][p] = 1;
    tick();
    clear_stim();
    for (int i = 0; i < 300; i++) begin
      rq[0][0] = 1; ad[0][0] = 3; rq[0][1] = 1; ad[0][1] = 3;
      tick();
    end
    check("cnt_a_saturated", 64'(cnt_a), 64'd255);
    cl[0] = 1;
    tick();
    clear_stim();
    tick();
`ifdef REGWR_LOCK_EN
    lwe_i = 1; laddr_i = 7; lval_i = 1;
    tick();
    clear_stim();
    rq[0][0] = 1; ad[0][0] = 7;
    tick();
    lwe_i = 1; laddr_i = 7; lval_i = 0;
    tick();
    clear_stim();
    rq[0][0] = 1; ad[0][0] = 7;
    tick();
    clear_stim();
`endif
    rq[0][0] = 1; ad[0][0] = 12; rq[1][1] = 1; ad[1][1] = 12;
    tick();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    compare(0);
    compare(1);
    @(posedge clk);
    #1;
    compare(0);
    compare(1);
    clear_stim();
    apply();
    @(negedge clk) rst_n = 1'b1;
    tick();
    for (int i = 0; i < 600; i++) begin
      clear_stim();
      for (int d = 0; d < 2; d++) begin
        cl[d] = ($urandom_range(0, 19) == 0) ? 1 : 0;
        for (int p = 0; p < 4; p++) begin
          rq[d][p] = $urandom_range(0, 1);
          ad[d][p] = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 3) : $urandom_range(0, 31);
        end
      end
`ifdef REGWR_LOCK_EN
      lwe_i = ($urandom_range(0, 3) == 0) ? 1 : 0;
      laddr_i = $urandom_range(0, 31);
      lval_i = $urandom_range(0, 1);
`endif
      tick();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
